// File: rtl/sdram_fifo_arb.sv
// sdram_fifo_arb: decides when a fixed-length SDRAM burst may start.
// A burst is requested once every enabled read channel holds more than
// RD_MIN words and the write FIFO has room. After grant, the block counts
// BURST_LEN beats, pulses done, then holds off for GAP_CYC cycles.
// A beat taken while a latched channel is empty raises a sticky underrun flag.
module sdram_fifo_arb #(
    parameter int NCH       = 4,
    parameter int RD_W      = 15,
    parameter int WR_W      = 13,
    parameter int WR_MAX    = 4000,
    parameter int RD_MIN    = 100,
    parameter int BURST_LEN = 256,
    parameter int GAP_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 en,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [NCH*RD_W-1:0]  usedw_rd,
    input  logic [WR_W-1:0]      usedw_wr,
    input  logic                 grant,
    input  logic                 beat,
    output logic                 req,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          burst_cnt,
    output logic                 err_underrun
);

    localparam int CW = $clog2(BURST_LEN + 1);
    // Two extra states keep the gap counter at least one bit wide when GAP_CYC is 0.
    localparam int GW = $clog2(GAP_CYC + 2);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    // Thresholds widened to 32 bits so both compare operands are zero-extended.
    localparam logic [31:0] WR_MAX_U = WR_MAX;
    localparam logic [31:0] RD_MIN_U = RD_MIN;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST,
        GAP
    } state_t;

    state_t          state;
    logic [NCH-1:0]  mask_q;
    logic [CW-1:0]   beat_cnt;
    logic [GW-1:0]   gap_cnt;

    logic [NCH-1:0]  rd_above;
    logic [NCH-1:0]  rd_empty;
    logic            ok;

    // Per-channel threshold and empty flags, combined into the start condition.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        rd_above = '0;
        rd_empty = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_above[i] = 32'(usedw_rd[i*RD_W +: RD_W]) > RD_MIN_U;
            rd_empty[i] = (usedw_rd[i*RD_W +: RD_W] == '0);
        end
        // Disabled channels are forced "above" so they never block a burst.
        ok = en && (ch_mask != '0) && (32'(usedw_wr) < WR_MAX_U)
                && ((rd_above | ~ch_mask) == '1);
    end

    // Burst control FSM with registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            req          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            burst_cnt    <= '0;
            err_underrun <= 1'b0;
            mask_q       <= '0;
            beat_cnt     <= '0;
            gap_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees the
            // pre-edge values of the others regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The only place the sticky underrun flag can be cleared.
                    if (!en) err_underrun <= 1'b0;
                    if (ok) begin
                        state <= REQ;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                REQ: begin
                    // Grant wins over a simultaneous loss of ok.
                    if (grant) begin
                        state    <= BURST;
                        req      <= 1'b0;
                        mask_q   <= ch_mask;
                        beat_cnt <= '0;
                    end else if (!ok) begin
                        state <= IDLE;
                        req   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                BURST: begin
                    // No abort: en, ok and ch_mask are not looked at here.
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if ((mask_q & rd_empty) != '0) err_underrun <= 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            done      <= 1'b1;
                            burst_cnt <= burst_cnt + 16'd1;
                            gap_cnt   <= '0;
                            if (GAP_CYC == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_fifo_arb.sv
// Directed bench for sdram_fifo_arb: request/withdraw, full bursts with gap,
// ignored beats, underrun set/clear, blocked start conditions and async reset.
// Completed bursts are scoreboarded: the expected burst count is queued when
// the last beat is driven and compared when done pulses.
module tb_sdram_fifo_arb;

    localparam int NCH       = 4;
    localparam int RD_W      = 15;
    localparam int WR_W      = 13;
    localparam int BURST_LEN = 256;
    localparam int GAP_CYC   = 4;

    logic                clk;
    logic                nRST;
    logic                en;
    logic [NCH-1:0]      ch_mask;
    logic [NCH*RD_W-1:0] usedw_rd;
    logic [WR_W-1:0]     usedw_wr;
    logic                grant;
    logic                beat;
    logic                req;
    logic                busy;
    logic                done;
    logic [15:0]         burst_cnt;
    logic                err_underrun;

    int vectors     = 0;
    int miscompares = 0;
    int exp_bursts  = 0;
    logic [15:0] sb[$];

    sdram_fifo_arb #(
        .NCH(NCH), .RD_W(RD_W), .WR_W(WR_W), .WR_MAX(4000), .RD_MIN(100),
        .BURST_LEN(BURST_LEN), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .nRST(nRST), .en(en), .ch_mask(ch_mask),
        .usedw_rd(usedw_rd), .usedw_wr(usedw_wr), .grant(grant), .beat(beat),
        .req(req), .busy(busy), .done(done), .burst_cnt(burst_cnt),
        .err_underrun(err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then stable and new inputs may be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int ch, input int val);
        usedw_rd[ch*RD_W +: RD_W] = RD_W'(val);
    endtask

    task automatic set_all_rd(input int val);
        for (int i = 0; i < NCH; i++) set_rd(i, val);
    endtask

    // Drive n beats; if 'last', the final one completes the burst.
    task automatic do_beats(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            bit fin;
            fin  = last && (i == n - 1);
            beat = 1'b1;
            if (fin) begin
                exp_bursts = (exp_bursts + 1) % 65536;
                sb.push_back(16'(exp_bursts));
            end
            step();
            check("done_pulse", done, fin);
        end
        beat = 1'b0;
    endtask

    task automatic wait_req(input int limit);
        int n;
        n = 0;
        while (req !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check("req_wait", req, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, req, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_burst_cnt"}, burst_cnt, 16'd0);
        check({tag, "_err"}, err_underrun, 1'b0);
    endtask

    // Scoreboard side: every done pulse must match a queued burst count.
    always @(negedge clk) begin
        if (nRST === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) check("done_spurious", 1'b1, 1'b0);
            else check("burst_cnt_sb", burst_cnt, sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        nRST = 1'b0; en = 1'b1; ch_mask = 4'hF; usedw_wr = 13'd3999;
        grant = 1'b0; beat = 1'b0; usedw_rd = '0;
        set_all_rd(101);
        step(); step();
        check_reset_outputs("reset");
        nRST = 1'b1;

        // Request raised one edge after ok, withdrawn when ch2 drops to RD_MIN.
        step();
        check("req_rise", req, 1'b1);
        check("busy_rise", busy, 1'b1);
        set_rd(2, 100);
        step();
        check("req_withdraw", req, 1'b0);
        check("busy_withdraw", busy, 1'b0);
        set_rd(2, 101);
        step();
        check("req_again", req, 1'b1);

        // One-cycle grant, then a full burst of consecutive beats.
        grant = 1'b1;
        step();
        grant = 1'b0;
        check("req_after_grant", req, 1'b0);
        check("busy_burst", busy, 1'b1);
        do_beats(BURST_LEN, 1'b1);
        check("burst_cnt_1", burst_cnt, 16'd1);

        // Gap: beats here are ignored; busy drops after GAP_CYC edges.
        beat = 1'b1;
        step(); check("done_clear", done, 1'b0);
        step(); step();
        check("busy_gap", busy, 1'b1);
        step();
        check("busy_idle", busy, 1'b0);
        check("req_idle", req, 1'b0);
        step();
        check("req_after_gap", req, 1'b1);

        // Beat in the grant cycle is not counted: 256 further beats needed.
        grant = 1'b1;
        step();
        grant = 1'b0;
        do_beats(BURST_LEN - 1, 1'b0);
        check("burst_cnt_not_yet", burst_cnt, 16'd1);
        do_beats(1, 1'b1);
        check("burst_cnt_2", burst_cnt, 16'd2);

        // Underrun: mask 0101, channels 1 and 3 empty but masked off.
        ch_mask = 4'b0101;
        set_rd(0, 200); set_rd(1, 0); set_rd(2, 200); set_rd(3, 0);
        wait_req(10);
        grant = 1'b1;
        step();
        grant = 1'b0;
        do_beats(10, 1'b0);
        check("err_before", err_underrun, 1'b0);
        set_rd(2, 0);
        beat = 1'b1;
        step();
        beat = 1'b0;
        check("err_set", err_underrun, 1'b1);
        set_rd(2, 200);
        do_beats(BURST_LEN - 12, 1'b0);
        do_beats(1, 1'b1);
        check("err_through_done", err_underrun, 1'b1);
        check("burst_cnt_3", burst_cnt, 16'd3);
        usedw_wr = 13'd4000;
        repeat (GAP_CYC + 2) step();
        check("busy_idle_err", busy, 1'b0);
        check("err_idle_en1", err_underrun, 1'b1);
        en = 1'b0;
        step();
        check("err_cleared", err_underrun, 1'b0);

        // Blocked starts: empty mask, then full write FIFO.
        en = 1'b1; usedw_wr = 13'd3999; ch_mask = 4'h0; set_all_rd(101);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (req) seen = 1'b1;
        end
        check("no_req_mask0", seen, 1'b0);
        ch_mask = 4'hF; usedw_wr = 13'd4000;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (req) seen = 1'b1;
        end
        check("no_req_wrfull", seen, 1'b0);

        // Reset mid-burst after 100 beats, then a fresh full burst.
        usedw_wr = 13'd3999;
        wait_req(5);
        grant = 1'b1;
        step();
        grant = 1'b0;
        do_beats(100, 1'b0);
        beat = 1'b1;
        #3 nRST = 1'b0;
        #1 check_reset_outputs("async_reset");
        beat = 1'b0;
        exp_bursts = 0;
        step();
        check_reset_outputs("held_reset");
        nRST = 1'b1;
        step();
        check("req_after_reset", req, 1'b1);
        grant = 1'b1;
        step();
        grant = 1'b0;
        do_beats(BURST_LEN - 1, 1'b0);
        do_beats(1, 1'b1);
        check("burst_cnt_post_reset", burst_cnt, 16'd1);

        step(); step();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
